dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. It is the far end of the load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake, then waits a configurable number of cycles.
- Returns read data or a write acknowledgement, with an error flag, over a second valid/ready handshake.
- Sits between the core's LSU request path and a word-organised SRAM array held inside the block. It is the multi-cycle replacement for the combinational dmem.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, minimum 4.
WAIT_STATES, 2, extra cycles between request accept and response; legal range 0..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i = byte lane i, little-endian
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load data; 0 for stores and for errored requests
rsp_err  output  1  request was misaligned or out of range
busy  output  1  a transaction is in progress (state != IDLE)

Behaviour:
- FSM states are IDLE, WAIT and RESP. Reset forces IDLE asynchronously.
- Output values at reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. req_ready=1 once reset deasserts. Array contents are not reset.
- req_ready = (state==IDLE). Only one transaction is outstanding; there is no pipelining.
- Accept occurs when req_valid && req_ready at a rising edge. On accept, the block:
  - captures we, addr, wdata and be;
  - computes err = (addr[1:0]!=0) || (addr < BASE_ADDR) || (addr >= BASE_ADDR + DEPTH_WORDS*4);
  - computes word index = (addr - BASE_ADDR) >> 2, truncated to clog2(DEPTH_WORDS) bits. The index is unused when err=1.
- IDLE to WAIT on accept if WAIT_STATES>0; the wait counter loads WAIT_STATES-1.
- IDLE to RESP on accept if WAIT_STATES==0.
- WAIT decrements the counter each cycle and moves to RESP on the edge where the counter is 0.
- Commit happens on the edge that enters RESP:
  - Store, err=0: write only the lanes with be=1. be=4'b0000 writes nothing and still responds with err=0.
  - Load, err=0: rsp_rdata is registered with the full word; be is ignored for loads.
  - err=1: no array write, rsp_rdata=0, rsp_err=1.
  - Store responses: rsp_rdata=0.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- RESP: rsp_valid=1, and rsp_rdata and rsp_err stay stable until the edge where rsp_ready=1. That edge moves the FSM to IDLE and clears rsp_valid, rsp_rdata and rsp_err.
- rsp_ready is ignored outside RESP. rsp_ready held high before rsp_valid rises gives a one-cycle RESP.
- Back-to-back: a request can be accepted in the cycle right after the response handshake. Peak throughput is one transaction per WAIT_STATES+2 cycles.
- req_valid asserted while busy has no effect, and the request is not queued. The requester must hold its request until req_ready.
- Load after store to the same address returns the new data, because the store committed before its response.
- Reset mid-transaction:
  - In WAIT, a pending store is discarded and the array is unchanged.
  - In RESP, the store has already committed and persists; the response is dropped.
  - All outputs return to their reset values immediately.
- Wrap-around: the address computation never wraps. Any address at or above the top of the range errors, including 32'hFFFF_FFFC.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, with rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0. A load from 0x10 then returns 0xDEADBEEF.
- Partial store: preload 0x11223344 at 0x20, store wdata=0xAABBCCDD with be=4'b0101 -> a load from 0x20 returns 0x11BB33DD.
- Error cases: a load from 0x22 (misaligned) and a store to 0x1000 (DEPTH=1024, out of range) -> each gives rsp_err=1, rsp_rdata=0, and the array is unchanged, checked by reading back 0x0 and 0xFFC.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a second req_valid is ignored. Release -> the FSM is in IDLE next cycle and a new request is accepted.
- WAIT_STATES=0 build: back-to-back load stream with rsp_ready=1 -> one response every 2 cycles, with latency exactly 1 cycle.
- Assert reset during WAIT of a store to 0x30 that previously held 0x5 -> outputs are cleared asynchronously, and after release a load from 0x30 returns 0x5.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store port between the core LSU (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait, then a
// registered response; holds a word-organised array with byte-lane writes.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;

  logic             cap_we;
  logic             cap_err;
  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;

  logic [31:0]      rdata;
  logic             err;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic [32:0]      off;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             live;
  logic             c_we;
  logic             c_err;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_wdata;
  logic [3:0]       c_be;
  logic             enter_resp;
  logic [31:0]      mem_rd;

  // A 33-bit offset catches both addresses below the base (borrow) and at or
  // above the top of the range, so nothing wraps, including 32'hFFFF_FFFC.
  always_comb begin
    accept  = bus.req_valid && (state == S_IDLE);
    off     = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    req_err = (bus.req_addr[1:0] != 2'b00) || (off >= SPAN);
    req_idx = off[IDX_W+1:2];
  end

  // With no wait states the commit edge is the accept edge itself, so the
  // commit reads the live request instead of the captured copy.
  always_comb begin
    live    = (state == S_IDLE);
    c_we    = live ? bus.req_we    : cap_we;
    c_err   = live ? req_err       : cap_err;
    c_idx   = live ? req_idx       : cap_idx;
    c_wdata = live ? bus.req_wdata : cap_wdata;
    c_be    = live ? bus.req_be    : cap_be;
    if (WAIT_STATES == 0) begin
      enter_resp = accept;
    end else begin
      enter_resp = (state == S_WAIT) && (cnt == '0);
    end
    mem_rd = mem[c_idx];
  end

  always_ff @(posedge clk) begin
    if (reset && enter_resp && c_we && !c_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= bus.req_we;
        cap_err   <= req_err;
        cap_idx   <= req_idx;
        cap_wdata <= bus.req_wdata;
        cap_be    <= bus.req_be;
      end

      if (enter_resp) begin
        err   <= c_err;
        rdata <= (!c_we && !c_err) ? mem_rd : '0;
      end else if ((state == S_RESP) && bus.rsp_ready) begin
        err   <= 1'b0;
        rdata <= '0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance driven by directed and random
// transactions against an array model, plus a zero-wait instance for streaming.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          LAT_A = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if a();
  dmem_responder_if b();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .reset(reset), .bus(a)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .reset(reset), .bus(b)
  );

  logic [31:0] mem_m [DEPTH];
  logic [31:0] mem_b [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed view of the array, error if misaligned or outside [BASE, BASE+4*DEPTH).
  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] rd, output logic err);
    longint off;
    int     w;
    off = longint'(addr) - longint'(BASE);
    err = (addr % 4 != 0) || (off < 0) || (off >= longint'(DEPTH) * 4);
    rd  = '0;
    if (!err) begin
      w = int'(off / 4);
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mem_m[w][8*k +: 8] = wdata[8*k +: 8];
      end else begin
        rd = mem_m[w];
      end
    end
  endfunction

  // One transaction on the WAIT_STATES=2 instance; A is idle on entry (1 ns after an edge).
  task automatic txn_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit intrude, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    model(we, addr, wdata, be, exp_rd, exp_err);
    a.req_we    = we;
    a.req_addr  = addr;
    a.req_wdata = wdata;
    a.req_be    = be;
    a.req_valid = 1'b1;
    a.rsp_ready = (hold == 0);
    @(posedge clk); #1;
    a.req_valid = 1'b0;
    lat = 1;
    while (!a.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT_A));
    check({tag, "_rdata"}, a.rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(a.rsp_err), 32'(exp_err));
    if (hold > 0) begin
      if (intrude) begin
        a.req_valid = 1'b1;
        a.req_we    = 1'b1;
        a.req_addr  = 32'h0000_0040;
        a.req_wdata = 32'hCAFE_F00D;
        a.req_be    = 4'hF;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(a.rsp_valid), 32'd1);
        check({tag, "_hold_rdata"}, a.rsp_rdata, exp_rd);
        check({tag, "_hold_err"}, 32'(a.rsp_err), 32'(exp_err));
        check({tag, "_hold_req_ready"}, 32'(a.req_ready), 32'd0);
      end
      a.req_valid = 1'b0;
      a.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_done_valid"}, 32'(a.rsp_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(a.busy), 32'd0);
    check({tag, "_done_req_ready"}, 32'(a.req_ready), 32'd1);
    check({tag, "_done_rdata"}, a.rsp_rdata, 32'd0);
    a.rsp_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, wdata, exp_rd;
    logic [3:0]  be;
    logic        exp_err, we;
    int          n, acc, last_acc, kind;

    reset = 1'b0;
    a.req_valid = 1'b0; a.req_we = 1'b0; a.req_addr = '0; a.req_wdata = '0; a.req_be = '0;
    a.rsp_ready = 1'b0;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.req_be = '0;
    b.rsp_ready = 1'b0;

    #22;
    check("rst_a_rsp_valid", 32'(a.rsp_valid), 32'd0);
    check("rst_a_rsp_rdata", a.rsp_rdata, 32'd0);
    check("rst_a_rsp_err", 32'(a.rsp_err), 32'd0);
    check("rst_a_busy", 32'(a.busy), 32'd0);
    check("rst_b_rsp_valid", 32'(b.rsp_valid), 32'd0);
    check("rst_b_busy", 32'(b.busy), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rst_a_req_ready", 32'(a.req_ready), 32'd1);
    check("rst_b_req_ready", 32'(b.req_ready), 32'd1);

    for (int w = 0; w < int'(DEPTH); w++)
      txn_a(1'b1, BASE + 32'(w * 4), $urandom, 4'hF, 0, 1'b0, "init");

    txn_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, "st_10");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "ld_10");
    txn_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 1'b0, "st_20_full");
    txn_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, "st_20_part");
    txn_a(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, "ld_20_merged");
    txn_a(1'b1, 32'h24, 32'h1234_5678, 4'b0000, 0, 1'b0, "st_24_be0");
    txn_a(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, "ld_24_after_be0");
    txn_a(1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0, "ld_misaligned");
    txn_a(1'b1, 32'h1000, 32'h5555_AAAA, 4'hF, 0, 1'b0, "st_out_of_range");
    txn_a(1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF, 0, 1'b0, "st_top_addr");
    txn_a(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, "ld_0");
    txn_a(1'b0, 32'hFFC, 32'h0, 4'hF, 0, 1'b0, "ld_ffc");

    txn_a(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, "ld_backpressure");
    txn_a(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, "ld_40_no_intruder");

    // Reset while a store sits in WAIT: the store must be discarded.
    txn_a(1'b1, 32'h30, 32'h0000_0005, 4'hF, 0, 1'b0, "st_30_preload");
    a.req_we = 1'b1; a.req_addr = 32'h30; a.req_wdata = 32'hFFFF_FFFF; a.req_be = 4'hF;
    a.req_valid = 1'b1; a.rsp_ready = 1'b0;
    @(posedge clk); #1;
    a.req_valid = 1'b0;
    check("wait_busy_before_reset", 32'(a.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("wait_rst_busy", 32'(a.busy), 32'd0);
    check("wait_rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
    check("wait_rst_rsp_rdata", a.rsp_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    txn_a(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, "ld_30_after_wait_reset");

    // Reset while a store sits in RESP: the store has committed and persists.
    a.req_we = 1'b1; a.req_addr = 32'h34; a.req_wdata = 32'h89AB_CDEF; a.req_be = 4'hF;
    a.req_valid = 1'b1; a.rsp_ready = 1'b0;
    @(posedge clk); #1;
    a.req_valid = 1'b0;
    n = 1;
    while (!a.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_store_latency", 32'(n), 32'(LAT_A));
    model(1'b1, 32'h34, 32'h89AB_CDEF, 4'hF, exp_rd, exp_err);
    #2 reset = 1'b0;
    #1;
    check("resp_rst_rsp_valid", 32'(a.rsp_valid), 32'd0);
    check("resp_rst_busy", 32'(a.busy), 32'd0);
    check("resp_rst_rsp_err", 32'(a.rsp_err), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    txn_a(1'b0, 32'h34, 32'h0, 4'hF, 0, 1'b0, "ld_34_after_resp_reset");

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind == 7) addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 8) addr = (($urandom % 2) == 0) ? 32'hFFFF_FFFC : BASE + 32'(DEPTH * 4) + ($urandom & 32'h00FF_FFFC);
      else                addr = $urandom;
      we = 1'($urandom % 2);
      be = 4'($urandom_range(0, 15));
      txn_a(we, addr, $urandom, be, $urandom_range(0, 2), 1'b0, "rand");
    end

    // Zero-wait instance: stores then loads streamed with req_valid and rsp_ready held high.
    b.rsp_ready = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 16; k++) begin
      we    = (k < 8);
      addr  = 32'h100 + 32'((k % 8) * 4);
      wdata = $urandom;
      b.req_we = we; b.req_addr = addr; b.req_wdata = wdata; b.req_be = 4'hF;
      b.req_valid = 1'b1;
      n = 0;
      while (!b.req_ready && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (!b.req_ready) check("b_ready_timeout", 32'(b.req_ready), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      check("b_rsp_valid_lat1", 32'(b.rsp_valid), 32'd1);
      check("b_rsp_err", 32'(b.rsp_err), 32'd0);
      check("b_rsp_rdata", b.rsp_rdata, we ? 32'd0 : mem_b[k % 8]);
      if (k > 0) check("b_gap", 32'(acc - last_acc), 32'd2);
      last_acc = acc;
      if (we) mem_b[k % 8] = wdata;
    end
    b.req_valid = 1'b0;
    @(posedge clk); #1;
    check("b_idle_after_stream", 32'(b.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
